core_opr: RTL and testbench

Operand-read and issue stage for the TOY core: the reading and arbitrating side of the architectural register file. It accepts one decoded instruction per cycle, drives the two ARF read ports, and keeps a 16-entry pending-write scoreboard to block RAW and WAW hazards. It forwards same-cycle writeback data that has not yet reached the ARF, then presents the instruction with its captured operands to EX/MEM through a registered valid/ready issue slot.

---
 rtl/core_pkg.sv | 27 ++
 rtl/core_opr_scoreboard.sv | 46 ++++
 rtl/core_opr.sv | 114 +++++++++++
 tb/tb_core_opr.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared widths, writeback port count and issue-slot payload for the TOY core operand stage.
`ifndef SSC_EX
`define SSC_EX 1
`endif
`ifndef SSC_MEM
`define SSC_MEM 1
`endif

package core_pkg;

    localparam int unsigned NUM_WB_PORTS = `SSC_EX + `SSC_MEM;
    localparam int unsigned NUM_REGS     = 16;
    localparam int unsigned REG_IDX_W    = 4;
    localparam int unsigned XLEN         = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    typedef struct packed {
        word_t    insn;
        word_t    a;
        word_t    b;
        reg_idx_t rd;
        logic     rd_en;
    } opr_issue_t;

endpackage

// File: rtl/core_opr_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by issue, cleared by
// writeback or by flushing the issue slot; same-cycle set beats clear (younger writer wins).
module core_opr_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned WB_PORTS = NUM_WB_PORTS
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic                                set_en_i,
    input  reg_idx_t                            set_idx_i,
    input  logic                                kill_en_i,
    input  reg_idx_t                            kill_idx_i,
    input  logic [WB_PORTS-1:0]                 wb_en_i,
    input  logic [WB_PORTS-1:0][REG_IDX_W-1:0]  wb_addr_i,
    output logic [NUM_REGS-1:0]                 pending_o,
    output logic [NUM_REGS-1:0]                 wb_hit_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (wb_en_i[p]) wb_hit[wb_addr_i[p]] = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q & ~wb_hit;
        if (kill_en_i) pending_d[kill_idx_i] = 1'b0;
        if (set_en_i)  pending_d[set_idx_i]  = 1'b1;
        // R0 is never written, so it can never be pending
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign pending_o = pending_q;
    assign wb_hit_o  = wb_hit;

endmodule

// File: rtl/core_opr.sv
// Operand read/issue: RAW/WAW hazard check, writeback forwarding, registered issue slot.
// Decode-to-issue latency 1 cycle; dec_ready_o drops on hazard, flush, or full slot not draining.
module core_opr
    import core_pkg::*;
#(
    parameter int unsigned WB_PORTS = NUM_WB_PORTS
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic                                flush_i,
    input  logic                                dec_valid_i,
    output logic                                dec_ready_o,
    input  logic [XLEN-1:0]                     dec_insn_i,
    input  logic [REG_IDX_W-1:0]                dec_rs_i,
    input  logic [REG_IDX_W-1:0]                dec_rt_i,
    input  logic [REG_IDX_W-1:0]                dec_rd_i,
    input  logic                                dec_rd_en_i,
    output logic [REG_IDX_W-1:0]                ra_addr_o,
    output logic [REG_IDX_W-1:0]                rb_addr_o,
    input  logic [XLEN-1:0]                     ra_data_i,
    input  logic [XLEN-1:0]                     rb_data_i,
    input  logic [WB_PORTS-1:0]                 wb_en_i,
    input  logic [WB_PORTS-1:0][REG_IDX_W-1:0]  wb_addr_i,
    input  logic [WB_PORTS-1:0][XLEN-1:0]       wb_data_i,
    output logic                                iss_valid_o,
    input  logic                                iss_ready_i,
    output logic [XLEN-1:0]                     iss_insn_o,
    output logic [XLEN-1:0]                     iss_a_o,
    output logic [XLEN-1:0]                     iss_b_o,
    output logic [REG_IDX_W-1:0]                iss_rd_o,
    output logic                                iss_rd_en_o
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] wb_hit;
    logic                rs_rdy, rt_rdy, waw, stall, accept;
    word_t               opa, opb;
    opr_issue_t          iss_q, iss_d;
    logic                iss_valid_q, iss_valid_d;

    assign ra_addr_o = dec_rs_i;
    assign rb_addr_o = dec_rt_i;

    // A same-cycle writeback both satisfies a source and retires the older writer of rd
    assign rs_rdy = (dec_rs_i == '0) | ~pending[dec_rs_i] | wb_hit[dec_rs_i];
    assign rt_rdy = (dec_rt_i == '0) | ~pending[dec_rt_i] | wb_hit[dec_rt_i];
    assign waw    = dec_rd_en_i & (dec_rd_i != '0) & pending[dec_rd_i] & ~wb_hit[dec_rd_i];
    assign stall  = ~rs_rdy | ~rt_rdy | waw;

    assign dec_ready_o = ~stall & ~flush_i & (~iss_valid_q | iss_ready_i);
    assign accept      = dec_valid_i & dec_ready_o;

    core_opr_scoreboard #(
        .WB_PORTS (WB_PORTS)
    ) u_sb (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .set_en_i   (accept & dec_rd_en_i & (dec_rd_i != '0)),
        .set_idx_i  (dec_rd_i),
        .kill_en_i  (flush_i & iss_valid_q & iss_q.rd_en),
        .kill_idx_i (iss_q.rd),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .pending_o  (pending),
        .wb_hit_o   (wb_hit)
    );

    // Ascending scan so the highest-numbered matching port wins, as in the ARF
    always_comb begin
        opa = ra_data_i;
        opb = rb_data_i;
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (wb_en_i[p] && (wb_addr_i[p] == dec_rs_i)) opa = wb_data_i[p];
            if (wb_en_i[p] && (wb_addr_i[p] == dec_rt_i)) opb = wb_data_i[p];
        end
        if (dec_rs_i == '0) opa = '0;
        if (dec_rt_i == '0) opb = '0;
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        if (flush_i) begin
            iss_valid_d = 1'b0;
        end else if (accept) begin
            iss_valid_d = 1'b1;
            iss_d.insn  = dec_insn_i;
            iss_d.a     = opa;
            iss_d.b     = opb;
            iss_d.rd    = dec_rd_i;
            iss_d.rd_en = dec_rd_en_i;
        end else if (iss_ready_i) begin
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end

    assign iss_valid_o = iss_valid_q;
    assign iss_insn_o  = iss_q.insn;
    assign iss_a_o     = iss_q.a;
    assign iss_b_o     = iss_q.b;
    assign iss_rd_o    = iss_q.rd;
    assign iss_rd_en_o = iss_q.rd_en;

endmodule

// File: tb/tb_core_opr.sv
// Directed bench for core_opr: ARF model, expected-issue queue filled on accept, checked on drain.
module tb_core_opr;
    import core_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  arst_ni;
    logic                  flush_i;
    logic                  dec_valid_i;
    logic                  dec_ready_o;
    logic [15:0]           dec_insn_i;
    logic [3:0]            dec_rs_i, dec_rt_i, dec_rd_i;
    logic                  dec_rd_en_i;
    logic [3:0]            ra_addr_o, rb_addr_o;
    logic [15:0]           ra_data_i, rb_data_i;
    logic [1:0]            wb_en_i;
    logic [1:0][3:0]       wb_addr_i;
    logic [1:0][15:0]      wb_data_i;
    logic                  iss_valid_o;
    logic                  iss_ready_i;
    logic [15:0]           iss_insn_o, iss_a_o, iss_b_o;
    logic [3:0]            iss_rd_o;
    logic                  iss_rd_en_o;

    int                    n_vec = 0;
    int                    n_err = 0;
    logic [15:0]           arf [16];
    logic [15:0]           exp_a, exp_b;
    opr_issue_t            exp_q [$];
    opr_issue_t            mon_e;

    core_opr dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .flush_i     (flush_i),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .dec_insn_i  (dec_insn_i),
        .dec_rs_i    (dec_rs_i),
        .dec_rt_i    (dec_rt_i),
        .dec_rd_i    (dec_rd_i),
        .dec_rd_en_i (dec_rd_en_i),
        .ra_addr_o   (ra_addr_o),
        .rb_addr_o   (rb_addr_o),
        .ra_data_i   (ra_data_i),
        .rb_data_i   (rb_data_i),
        .wb_en_i     (wb_en_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .iss_valid_o (iss_valid_o),
        .iss_ready_i (iss_ready_i),
        .iss_insn_o  (iss_insn_o),
        .iss_a_o     (iss_a_o),
        .iss_b_o     (iss_b_o),
        .iss_rd_o    (iss_rd_o),
        .iss_rd_en_o (iss_rd_en_o)
    );

    always #5 clk_i = ~clk_i;

    // ARF model: R0 deliberately returns all-ones so the stage must force it to zero
    assign ra_data_i = arf[ra_addr_o];
    assign rb_data_i = arf[rb_addr_o];

    always @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < 16; i++) arf[i] <= 16'h0;
            arf[0] <= 16'hFFFF;
            arf[1] <= 16'd5;
            arf[2] <= 16'd7;
        end else begin
            for (int p = 0; p < 2; p++)
                if (wb_en_i[p] && wb_addr_i[p] != 4'd0) arf[wb_addr_i[p]] <= wb_data_i[p];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue-side scoreboard: pop on drain (compare) or flush (discard), push on accept
    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (iss_valid_o && (iss_ready_i || flush_i)) begin
                if (exp_q.size() == 0) begin
                    chk("iss_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!flush_i) begin
                        chk("q_insn",  iss_insn_o,  mon_e.insn);
                        chk("q_a",     iss_a_o,     mon_e.a);
                        chk("q_b",     iss_b_o,     mon_e.b);
                        chk("q_rd",    iss_rd_o,    mon_e.rd);
                        chk("q_rd_en", iss_rd_en_o, mon_e.rd_en);
                    end
                end
            end
            if (dec_valid_i && dec_ready_o)
                exp_q.push_back('{insn: dec_insn_i, a: exp_a, b: exp_b,
                                  rd: dec_rd_i, rd_en: dec_rd_en_i});
        end
    end

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dec(input logic v, input logic [15:0] insn, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic rd_en,
                       input logic [15:0] ea, input logic [15:0] eb);
        dec_valid_i = v;
        dec_insn_i  = insn;
        dec_rs_i    = rs;
        dec_rt_i    = rt;
        dec_rd_i    = rd;
        dec_rd_en_i = rd_en;
        exp_a       = ea;
        exp_b       = eb;
    endtask

    task automatic wb(input logic [1:0] en, input logic [3:0] a0, input logic [15:0] d0,
                      input logic [3:0] a1, input logic [15:0] d1);
        wb_en_i      = en;
        wb_addr_i[0] = a0;
        wb_data_i[0] = d0;
        wb_addr_i[1] = a1;
        wb_data_i[1] = d1;
    endtask

    initial begin
        arst_ni     = 1'b0;
        flush_i     = 1'b0;
        iss_ready_i = 1'b1;
        dec(1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
        wb(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        #1;
        chk("rst_iss_valid", iss_valid_o, 1'b0);
        chk("rst_iss_insn",  iss_insn_o,  16'h0);
        chk("rst_iss_a",     iss_a_o,     16'h0);
        chk("rst_pending",   dut.pending, 16'h0);
        chk("rst_dec_ready", dec_ready_o, 1'b1);
        @(posedge clk_i);
        nxt();
        arst_ni = 1'b1;

        // R3 <- R1 + R2
        dec(1'b1, 16'h1312, 4'd1, 4'd2, 4'd3, 1'b1, 16'd5, 16'd7);
        #1;
        chk("basic_ready", dec_ready_o, 1'b1);
        chk("ra_addr",     ra_addr_o,   4'd1);
        chk("rb_addr",     rb_addr_o,   4'd2);

        // R4 <- R3 + R1: RAW on R3
        nxt();
        dec(1'b1, 16'h2431, 4'd3, 4'd1, 4'd4, 1'b1, 16'h00AA, 16'd5);
        #1;
        chk("basic_valid", iss_valid_o, 1'b1);
        chk("basic_a",     iss_a_o,     16'd5);
        chk("basic_b",     iss_b_o,     16'd7);
        chk("basic_rd",    iss_rd_o,    4'd3);
        chk("basic_pend",  dut.pending, 16'h0008);
        chk("raw_stall",   dec_ready_o, 1'b0);

        nxt();
        wb(2'b01, 4'd3, 16'h00AA, 4'd0, 16'h0);
        #1;
        chk("raw_fwd_ready", dec_ready_o, 1'b1);
        chk("drained",       iss_valid_o, 1'b0);

        // Both ports write R5; port 1 must win
        nxt();
        chk("fwd_a",       iss_a_o,     16'h00AA);
        chk("raw_pend",    dut.pending, 16'h0010);
        dec(1'b1, 16'h4650, 4'd5, 4'd0, 4'd6, 1'b1, 16'h2222, 16'h0);
        wb(2'b11, 4'd5, 16'h1111, 4'd5, 16'h2222);
        #1;
        chk("prio_ready", dec_ready_o, 1'b1);

        nxt();
        chk("prio_a",  iss_a_o, 16'h2222);
        chk("r0_rt_b", iss_b_o, 16'h0);
        dec(1'b1, 16'h5311, 4'd1, 4'd1, 4'd3, 1'b1, 16'd5, 16'd5);
        wb(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        #1;
        chk("waw0_ready", dec_ready_o, 1'b1);

        // Second writer of R3 while R3 pending
        nxt();
        dec(1'b1, 16'h6312, 4'd1, 4'd2, 4'd3, 1'b1, 16'd5, 16'd7);
        #1;
        chk("waw_pend",  dut.pending, 16'h0058);
        chk("waw_stall", dec_ready_o, 1'b0);

        nxt();
        chk("waw_stall2", dec_ready_o, 1'b0);
        wb(2'b01, 4'd3, 16'h0BBB, 4'd0, 16'h0);
        iss_ready_i = 1'b0;
        #1;
        chk("waw_release", dec_ready_o, 1'b1);

        // Slot held under backpressure
        for (int c = 0; c < 3; c++) begin
            nxt();
            dec(1'b1, 16'h7712, 4'd1, 4'd2, 4'd7, 1'b1, 16'd5, 16'd7);
            wb(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
            #1;
            if (c == 0) chk("set_wins_pend", dut.pending, 16'h0058);
            chk("bp_valid", iss_valid_o, 1'b1);
            chk("bp_insn",  iss_insn_o,  16'h6312);
            chk("bp_a",     iss_a_o,     16'd5);
            chk("bp_b",     iss_b_o,     16'd7);
            chk("bp_rd",    iss_rd_o,    4'd3);
            chk("bp_ready", dec_ready_o, 1'b0);
        end

        nxt();
        dec(1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
        flush_i = 1'b1;
        #1;
        chk("flush_no_accept", dec_ready_o, 1'b0);

        // R0 as destination and as source
        nxt();
        flush_i     = 1'b0;
        iss_ready_i = 1'b1;
        chk("flush_valid", iss_valid_o, 1'b0);
        chk("flush_pend",  dut.pending, 16'h0050);
        dec(1'b1, 16'h8021, 4'd0, 4'd1, 4'd0, 1'b1, 16'h0, 16'd5);
        #1;
        chk("r0_ready", dec_ready_o, 1'b1);

        nxt();
        chk("r0_a",     iss_a_o,     16'h0);
        chk("r0_b",     iss_b_o,     16'd5);
        chk("r0_pend",  dut.pending, 16'h0050);
        dec(1'b1, 16'h9822, 4'd2, 4'd2, 4'd8, 1'b1, 16'd7, 16'd7);
        #1;
        chk("b2b_ready", dec_ready_o, 1'b1);

        nxt();
        chk("b2b_insn",  iss_insn_o,  16'h9822);
        chk("b2b_pend",  dut.pending, 16'h0150);
        dec(1'b1, 16'hA941, 4'd4, 4'd1, 4'd9, 1'b1, 16'h0, 16'd5);
        #1;
        chk("r4_stall", dec_ready_o, 1'b0);

        // Asynchronous reset in the middle of a stall
        nxt();
        #1;
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", iss_valid_o, 1'b0);
        chk("mid_rst_insn",  iss_insn_o,  16'h0);
        chk("mid_rst_pend",  dut.pending, 16'h0);
        chk("mid_rst_ready", dec_ready_o, 1'b1);
        dec(1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
        nxt();
        arst_ni = 1'b1;
        nxt();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
